// File: rtl/relu_seq_nbit.sv
// Sequential ReLU over an M-element vector of N-bit signed values.
// The FSM captures the vector on start and writes one result element per
// cycle. Define RELU_POSCNT_EN to compile in the pos_cnt output, which
// counts the strictly positive elements of the vector.

// One lane: combinational ReLU of a single signed element.
module relu_seq_nbit_lane #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_x,
  output logic [N-1:0] o_y
);
  // Negative elements clamp to zero; zero and positive pass through.
  always_comb begin
    o_y = i_x[N-1] ? '0 : i_x;
  end
endmodule

module relu_seq_nbit #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*M-1:0] s_vec,
  output logic           busy,
  output logic           done,
  output logic [N*M-1:0] o_vec
`ifdef RELU_POSCNT_EN
  ,
  output logic [$clog2(M+1)-1:0] pos_cnt
`endif
);
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [M-1:0][N-1:0]   r_buf;
  logic [M-1:0][N-1:0]   r_ovec;
  logic                  r_busy;
  logic                  r_done;
  logic [M-1:0][N-1:0]   w_relu;
  logic [M-1:0]          w_sel;
  logic                  w_last;

  // One ReLU lane per element; the FSM picks the lane matching idx.
  for (genvar k = 0; k < M; k++) begin : g_lane
    relu_seq_nbit_lane #(.N(N)) u_lane (
      .i_x (r_buf[k]),
      .o_y (w_relu[k])
    );
    assign w_sel[k] = (r_idx == IW'(k));
  end

  assign w_last = (r_idx == IW'(M-1));

  // Control FSM: capture, per-element write-back, one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_buf   <= '0;
      r_ovec  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_buf   <= s_vec;
            r_ovec  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < M; k++) begin
            if (w_sel[k]) r_ovec[k] <= w_relu[k];
          end
          if (w_last) begin
            // Wrap idx so it never points past the last element.
            r_idx   <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign o_vec = r_ovec;

`ifdef RELU_POSCNT_EN
  localparam int CW = $clog2(M+1);

  logic [CW-1:0] r_pos_cnt;
  logic          w_hit;

  // A lane output is nonzero exactly when its element is strictly positive.
  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < M; k++) begin
      if (w_sel[k] && (w_relu[k] != '0)) w_hit = 1'b1;
    end
  end

  // Positive-element counter: cleared on capture, bumped per positive RUN element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos_cnt <= '0;
    end else if (r_state == IDLE && start) begin
      r_pos_cnt <= '0;
    end else if (r_state == RUN) begin
      r_pos_cnt <= r_pos_cnt + CW'(w_hit);
    end
  end

  assign pos_cnt = r_pos_cnt;
`else
  // Counter not built: no pos_cnt port and no counting logic.
`endif

endmodule

// File: tb/tb_relu_seq_nbit.sv
// Bench for relu_seq_nbit: cycle-level behavioural model plus directed vectors.
module tb_relu_seq_nbit;
  localparam int N  = 8;
  localparam int M  = 4;
  localparam int CW = $clog2(M+1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N*M-1:0] s_vec = '0;
  logic           busy, done;
  logic [N*M-1:0] o_vec;
  logic [CW-1:0]  pos_cnt;

  logic           start1 = 1'b0;
  logic [N-1:0]   s1 = '0;
  logic           busy1, done1;
  logic [N-1:0]   o1;
  logic [0:0]     pos1;

  int n_chk = 0;
  int n_err = 0;
  bit fin = 0;

  always #5 clk = ~clk;

  relu_seq_nbit #(.N(N), .M(M)) u_dut (
    .clk(clk), .rst(rst), .start(start), .s_vec(s_vec),
    .busy(busy), .done(done), .o_vec(o_vec)
`ifdef RELU_POSCNT_EN
    , .pos_cnt(pos_cnt)
`endif
  );

  relu_seq_nbit #(.N(N), .M(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .s_vec(s1),
    .busy(busy1), .done(done1), .o_vec(o1)
`ifdef RELU_POSCNT_EN
    , .pos_cnt(pos1)
`endif
  );

`ifndef RELU_POSCNT_EN
  assign pos_cnt = '0;
  assign pos1    = '0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*M-1:0] relu_vec(input logic [N*M-1:0] v);
    logic [N*M-1:0] r;
    r = '0;
    for (int k = 0; k < M; k++)
      if ($signed(v[k*N +: N]) > 0) r[k*N +: N] = v[k*N +: N];
    return r;
  endfunction

  function automatic int pos_of(input logic [N*M-1:0] v);
    int c;
    c = 0;
    for (int k = 0; k < M; k++)
      if ($signed(v[k*N +: N]) > 0) c++;
    return c;
  endfunction

  // Model: a start in idle makes the block busy for M+1 cycles, done on the last.
  int             m_cnt;
  logic [N*M-1:0] m_o;
  int             m_pos;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_o   <= '0;
      m_pos <= 0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt <= M + 1;
        m_o   <= relu_vec(s_vec);
        m_pos <= pos_of(s_vec);
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Compare DUT against the model every cycle, on the falling edge.
  always @(negedge clk) begin
    if (!fin) begin
      chk("busy", busy, m_cnt > 0);
      chk("done", done, m_cnt == 1);
      if (m_cnt <= 1) begin
        chk("o_vec", o_vec, m_o);
`ifdef RELU_POSCNT_EN
        chk("pos_cnt", pos_cnt, m_pos[CW-1:0]);
`endif
      end
    end
  end

  // Issue one start pulse, then measure latency to done and busy duration.
  task automatic run_vec(input logic [N*M-1:0] v, output int lat, output int bcnt);
    @(posedge clk); #2;
    start = 1'b1; s_vec = v;
    @(posedge clk); #2;
    start = 1'b0; s_vec = ~v;
    lat = 0; bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  logic [N*M-1:0] tbl [4];
  logic [N*M-1:0] got [2];
  int lat, bcnt, nd;

  initial begin
    tbl[0] = 32'h10F02080; tbl[1] = 32'h7F7F7F7F;
    tbl[2] = 32'h81810101; tbl[3] = 32'h01020304;

    repeat (2) @(negedge clk);
    chk("rst_o_vec", o_vec, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2 rst = 1'b0;

    // {99,0,-67,-128}
    run_vec(32'h80BD0063, lat, bcnt);
    chk("v1_latency", lat, M + 1);
    chk("v1_o_vec", o_vec, 32'h00000063);
`ifdef RELU_POSCNT_EN
    chk("v1_pos_cnt", pos_cnt, 1);
`endif

    // {127,1,-1,0}
    run_vec(32'h00FF017F, lat, bcnt);
    chk("v2_o_vec", o_vec, 32'h0000017F);
    chk("v2_busy_cycles", bcnt, 5);
`ifdef RELU_POSCNT_EN
    chk("v2_pos_cnt", pos_cnt, 2);
`endif
    repeat (3) @(posedge clk);
    #2;

    // start held high with s_vec changing every cycle
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      start = 1'b1; s_vec = tbl[i % 4];
      @(negedge clk);
      if (done && nd < 2) begin got[nd] = o_vec; nd++; end
      @(posedge clk); #2;
    end
    start = 1'b0;
    chk("hold_done_count", nd, 2);
    chk("hold_first", got[0], 32'h10002000);
    chk("hold_second", got[1], 32'h00000101);
    repeat (8) @(posedge clk);
    #2;

    // reset in the RUN cycle processing idx=2
    start = 1'b1; s_vec = 32'h7F7F7F7F;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("abort_o_vec", o_vec, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk); #2 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_vec(32'h05050505, lat, bcnt);
    chk("after_abort_o_vec", o_vec, 32'h05050505);
    repeat (3) @(posedge clk);

    // M=1 instance: -128 then 64
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #2;
      start1 = 1'b1; s1 = (j == 0) ? 8'h80 : 8'h40;
      @(posedge clk); #2;
      start1 = 1'b0; s1 = 8'h11;
      lat = 0; bcnt = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        lat++;
        if (busy1) bcnt++;
        if (done1) break;
      end
      chk("m1_latency", lat, 2);
      chk("m1_busy_cycles", bcnt, 2);
      chk("m1_o_vec", o1, (j == 0) ? 8'h00 : 8'h40);
`ifdef RELU_POSCNT_EN
      chk("m1_pos_cnt", pos1, j);
`endif
      @(posedge clk); @(negedge clk);
      chk("m1_hold", o1, (j == 0) ? 8'h00 : 8'h40);
      chk("m1_idle_busy", busy1, 0);
    end

    repeat (3) @(posedge clk);
    fin = 1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
